midi_tx: RTL

Serializes MIDI messages onto a 31250-baud 8N1 serial line. This is the transmit end of the serial MIDI link whose receive end feeds the synth voice engine. It accepts one 1–3 byte message per valid/ready handshake and applies optional running-status compression. Used for MIDI-thru/echo, loopback test stimulus, and driving external gear.

---
 rtl/midi_pkg.sv | 25 ++
 rtl/midi_uart_tx_byte.sv | 93 +++++++++
 rtl/midi_tx.sv | 105 ++++++++++
 3 files changed

// File: rtl/midi_pkg.sv
// Shared MIDI constants and helpers used by both ends of the serial MIDI link.
// The status-range constants and message-type codes are common to transmitter and receiver.
package midi_pkg;

  localparam logic [7:0] CH_VOICE_MIN   = 8'h80;
  localparam logic [7:0] CH_VOICE_MAX   = 8'hEF;
  localparam logic [7:0] SYS_COMMON_MIN = 8'hF0;
  localparam logic [7:0] REALTIME_MIN   = 8'hF8;

  localparam logic [3:0] NOTE_OFF = 4'h8;
  localparam logic [3:0] NOTE_ON  = 4'h9;
  localparam logic [3:0] CC       = 4'hB;

  typedef enum logic [1:0] {SEQ_IDLE, SEQ_STATUS, SEQ_D1, SEQ_D2} seq_state_t;
  typedef enum logic [1:0] {BIT_IDLE, BIT_START, BIT_DATA, BIT_STOP} bit_state_t;

  function automatic logic is_ch_voice(input logic [7:0] s);
    return (s >= CH_VOICE_MIN) && (s <= CH_VOICE_MAX);
  endfunction

  function automatic logic is_sys_common(input logic [7:0] s);
    return (s >= SYS_COMMON_MIN) && (s < REALTIME_MIN);
  endfunction

endpackage

// File: rtl/midi_uart_tx_byte.sv
// 8N1 byte serializer with its own baud counter.
// A new byte may be loaded in the cycle its predecessor's stop bit ends.
module midi_uart_tx_byte
  import midi_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 3200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] data,
  output logic       tx,
  output logic       idle,
  output logic       done
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  bit_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       shreg_q, shreg_d;
  logic             tx_q, tx_d;
  logic             tick;

  always_comb begin
    tick    = (cnt_q == CNT_LAST);
    state_d = state_q;
    cnt_d   = tick ? '0 : cnt_q + 1'b1;
    idx_d   = idx_q;
    shreg_d = shreg_q;
    tx_d    = tx_q;
    done    = (state_q == BIT_STOP) && tick;

    case (state_q)
      BIT_IDLE: cnt_d = '0;
      BIT_START: begin
        if (tick) begin
          state_d = BIT_DATA;
          idx_d   = '0;
          tx_d    = shreg_q[0];
          shreg_d = shreg_q >> 1;
        end
      end
      BIT_DATA: begin
        if (tick) begin
          if (idx_q == 3'd7) begin
            state_d = BIT_STOP;
            tx_d    = 1'b1;
          end else begin
            idx_d   = idx_q + 3'd1;
            tx_d    = shreg_q[0];
            shreg_d = shreg_q >> 1;
          end
        end
      end
      BIT_STOP: begin
        if (tick) state_d = BIT_IDLE;
      end
      default: state_d = BIT_IDLE;
    endcase

    // Loading on the stop-bit terminal count keeps message bytes back to back.
    if (start && ((state_q == BIT_IDLE) || done)) begin
      state_d = BIT_START;
      cnt_d   = '0;
      idx_d   = '0;
      shreg_d = data;
      tx_d    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= BIT_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shreg_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
      tx_q    <= tx_d;
    end
  end

  assign tx   = tx_q;
  assign idle = (state_q == BIT_IDLE);

endmodule

// File: rtl/midi_tx.sv
// MIDI message transmitter: latches a 1-3 byte message, applies running-status
// compression and sequences the bytes through the 8N1 serializer.
module midi_tx
  import midi_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ    = 100000000,
  parameter int unsigned BAUD           = 31250,
  parameter bit          RUNNING_STATUS = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       msg_valid,
  output logic       msg_ready,
  input  logic [7:0] msg_status,
  input  logic [6:0] msg_data1,
  input  logic [6:0] msg_data2,
  input  logic [1:0] msg_len,
  output logic       midi_out,
  output logic       busy
);

  localparam int unsigned CLKS_PER_BIT = CLK_FREQ_HZ / BAUD;

  seq_state_t state_q, state_d;
  logic [6:0] d1_q, d2_q;
  logic [1:0] len_q;
  logic [7:0] rs_q;
  logic       rs_valid_q;

  logic [7:0] status_w;
  logic [1:0] len_w;
  logic       accept, skip_status, from_inputs;
  logic       byte_start, byte_idle, byte_done;
  logic [7:0] byte_data;

  assign busy      = (state_q != SEQ_IDLE);
  assign msg_ready = !busy;

  always_comb begin
    status_w    = {1'b1, msg_status[6:0]};
    len_w       = (msg_len == 2'd0) ? 2'd1 : msg_len;
    accept      = msg_valid && msg_ready;
    skip_status = RUNNING_STATUS && is_ch_voice(status_w) && rs_valid_q &&
                  (rs_q == status_w) && (len_w >= 2'd2);
    from_inputs = (state_q == SEQ_IDLE);
    state_d     = state_q;

    case (state_q)
      SEQ_IDLE:   if (accept) state_d = skip_status ? SEQ_D1 : SEQ_STATUS;
      SEQ_STATUS: if (byte_done) state_d = (len_q >= 2'd2) ? SEQ_D1 : SEQ_IDLE;
      SEQ_D1:     if (byte_done) state_d = (len_q == 2'd3) ? SEQ_D2 : SEQ_IDLE;
      SEQ_D2:     if (byte_done) state_d = SEQ_IDLE;
      default:    state_d = SEQ_IDLE;
    endcase

    // The first byte launches on the accepting edge straight from the inputs;
    // later bytes come from the latch as each predecessor finishes.
    byte_start = (state_d != SEQ_IDLE) && (byte_idle || byte_done);
    case (state_d)
      SEQ_STATUS: byte_data = status_w;
      SEQ_D1:     byte_data = from_inputs ? {1'b0, msg_data1} : {1'b0, d1_q};
      SEQ_D2:     byte_data = {1'b0, d2_q};
      default:    byte_data = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= SEQ_IDLE;
      d1_q       <= '0;
      d2_q       <= '0;
      len_q      <= '0;
      rs_q       <= '0;
      rs_valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        d1_q  <= msg_data1;
        d2_q  <= msg_data2;
        len_q <= len_w;
        if (RUNNING_STATUS) begin
          if (is_ch_voice(status_w)) begin
            rs_q       <= status_w;
            rs_valid_q <= 1'b1;
          end else if (is_sys_common(status_w)) begin
            rs_valid_q <= 1'b0;
          end
        end
      end
    end
  end

  midi_uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_byte (
    .clk  (clk),
    .rst  (rst),
    .start(byte_start),
    .data (byte_data),
    .tx   (midi_out),
    .idle (byte_idle),
    .done (byte_done)
  );

endmodule
